dpram_fifo_ctrl: RTL

Synchronous FIFO controller that owns both ports of the `Dual_port_ram` instance: port A is the write port and port B is the read port. It turns a push/pop interface into RAM addresses and write enables, and tracks occupancy. Flags are driven by the read/write pointers. The block sits between a producer and a consumer in the same clock domain and makes the dual-port RAM usable as a 64-entry buffer.

---
 rtl/dpram_fifo_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: FIFO controller. Port A of the dual-port RAM is the write port and port B is the read port.
// Latency: a pushed entry can be popped on the next cycle, and rd_data/rd_valid appear one cycle after the pop edge.
// Backpressure: a push while full and a pop while empty are dropped. Optional macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags.
module dpram_fifo_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 6,
  parameter int AFULL_LVL = 56
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] ram_data_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic              ram_we_a,
  output logic [DATA_W-1:0] ram_data_b,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic              ram_we_b,
`ifdef FIFO_ERR_FLAGS_EN
  output logic              overflow,
  output logic              underflow,
`endif
  input  logic [DATA_W-1:0] ram_q_b
);

  localparam logic [ADDR_W:0] AFULL_THR = AFULL_LVL[ADDR_W:0];

  // Pointers carry one extra wrap bit, so full and empty can be told apart.
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  // Flags and occupancy are decoded purely from the registered pointers.
  always_comb begin
    empty       = (wr_ptr == rd_ptr);
    full        = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                  (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    count       = wr_ptr - rd_ptr;
    almost_full = (count >= AFULL_THR);
  end

  // Accept decisions use the current-cycle flags. Writes are also blocked while reset is held.
  always_comb begin
    push_ok = wr_en & ~full & ~rst;
    pop_ok  = rd_en & ~empty & ~rst;
  end

  // RAM port wiring. Port B is read-only.
  always_comb begin
    ram_we_a   = push_ok;
    ram_addr_a = wr_ptr[ADDR_W-1:0];
    ram_data_a = wr_data;
    ram_addr_b = rd_ptr[ADDR_W-1:0];
    ram_we_b   = 1'b0;
    ram_data_b = '0;
    rd_data    = ram_q_b;
  end

  // Pointer advance. rd_valid follows the RAM's one-cycle read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      rd_valid <= pop_ok;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags. Only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en & full)  overflow  <= 1'b1;
      if (rd_en & empty) underflow <= 1'b1;
    end
  end
`endif

endmodule
